// File: rtl/wshb_arb_pkg.sv
// rtl/wshb_arb_pkg.sv - shared types and round-robin helper for the Wishbone N-master arbiter.
package wshb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_MASTERS     = 8;
  localparam int IDX_W           = 3;
  localparam int TIMEOUT_DEFAULT = 1024;

  function automatic int to_cnt_w(input int t);
    return (t > 2) ? $clog2(t) : 1;
  endfunction

  localparam int TIMEOUT_CNT_W = to_cnt_w(TIMEOUT_DEFAULT);

  // One-hot winner: first asserted request at or after last+1, wrapping modulo n.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                     input logic [IDX_W-1:0] last,
                                                     input int n);
    logic [MAX_MASTERS-1:0] win;
    logic [IDX_W-1:0]       sel;
    logic                   found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_MASTERS; k++) begin
      if (k <= n) begin
        sel = IDX_W'((int'(last) + k) % n);
        if (!found && req[sel]) begin
          win[sel] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/wshb_arbiter_n_rr_pointer.sv
// rtl/wshb_arbiter_n_rr_pointer.sv - rotating-priority core: holds the last served index and picks the next winner.
module rr_pointer
  import wshb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         load,
  output logic [N-1:0] winner
);

  logic [IDX_W-1:0]       last_q;
  logic [IDX_W-1:0]       win_idx;
  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_MASTERS-1:0] pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign pick   = rr_pick(req_ext, last_q, N);
  assign winner = pick[N-1:0];

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) win_idx = IDX_W'(i);
    end
  end

  // Reset points at the highest index so master 0 is first in line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= IDX_W'(N - 1);
    end else if (load && (|req)) begin
      last_q <= win_idx;
    end
  end

endmodule

// File: rtl/wshb_arbiter_n.sv
// rtl/wshb_arbiter_n.sv - round-robin N-master Wishbone arbiter, grant held per cyc; WSHB_ARB_TIMEOUT_EN adds stall timeout.
module wshb_arbiter_n
  import wshb_arb_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  parameter int DATA_BYTES = 2,
  parameter int ADDR_W     = 32,
  parameter int ADDR_SHIFT = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NB_MASTERS-1:0]          m_cyc,
  input  logic [NB_MASTERS-1:0]          m_stb,
  input  logic [NB_MASTERS-1:0]          m_we,
  input  logic [NB_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [NB_MASTERS*8*DATA_BYTES-1:0] m_dat_ms,
  input  logic [NB_MASTERS*DATA_BYTES-1:0] m_sel,
  output logic [8*DATA_BYTES-1:0]        m_dat_sm,
  output logic [NB_MASTERS-1:0]          m_ack,
  output logic [NB_MASTERS-1:0]          m_rty,
  output logic                           s_cyc,
  output logic                           s_stb,
  output logic                           s_we,
  output logic [ADDR_W-1:0]              s_adr,
  output logic [8*DATA_BYTES-1:0]        s_dat_ms,
  output logic [DATA_BYTES-1:0]          s_sel,
  input  logic [8*DATA_BYTES-1:0]        s_dat_sm,
  input  logic                           s_ack,
  input  logic                           s_rty,
  output logic [NB_MASTERS-1:0]          grant_o
`ifdef WSHB_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_o
`endif
);

  localparam int DW = 8 * DATA_BYTES;

  arb_state_t              state, state_nx;
  logic [NB_MASTERS-1:0]   grant, grant_nx;
  logic [NB_MASTERS-1:0]   winner;
  logic                    load;
  logic                    to_hit;

  logic                    g_cyc, g_stb, g_we;
  logic [ADDR_W-1:0]       g_adr;
  logic [DW-1:0]           g_dat;
  logic [DATA_BYTES-1:0]   g_sel;

  rr_pointer #(.N(NB_MASTERS)) u_rr (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (m_cyc),
    .load   (load),
    .winner (winner)
  );

  // Grant is zero outside BUSY, so the mux also zeroes the slave port when idle.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (grant[i]) begin
        g_cyc = m_cyc[i];
        g_stb = m_stb[i];
        g_we  = m_we[i];
        g_adr = m_adr[i*ADDR_W +: ADDR_W];
        g_dat = m_dat_ms[i*DW +: DW];
        g_sel = m_sel[i*DATA_BYTES +: DATA_BYTES];
      end
    end
  end

  assign s_cyc    = g_cyc & ~to_hit;
  assign s_stb    = g_stb & ~to_hit;
  assign s_we     = g_we;
  assign s_adr    = g_adr << ADDR_SHIFT;
  assign s_dat_ms = g_dat;
  assign s_sel    = g_sel;
  assign m_dat_sm = s_dat_sm;
  assign grant_o  = grant;

  // Late acks after the owner dropped cyc are swallowed here.
  always_comb begin
    m_ack = '0;
    m_rty = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (grant[i] && m_cyc[i]) begin
        m_ack[i] = s_ack;
        m_rty[i] = s_rty | to_hit;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    load     = 1'b0;
    case (state)
      IDLE: begin
        grant_nx = '0;
        if (|m_cyc) begin
          state_nx = BUSY;
          grant_nx = winner;
          load     = 1'b1;
        end
      end
      BUSY: begin
        if (!g_cyc || to_hit) begin
          state_nx = IDLE;
          grant_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
    end
  end

`ifdef WSHB_ARB_TIMEOUT_EN
  localparam int CNT_W = to_cnt_w(TIMEOUT);

  logic [CNT_W-1:0] to_cnt;

  assign to_hit = (state == BUSY) && g_cyc && g_stb && !s_ack &&
                  (to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if ((state != BUSY) || s_ack || to_hit) begin
        to_cnt <= '0;
      end else if (g_stb) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (to_hit) timeout_o <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign to_hit         = 1'b0;
  assign unused_timeout = |TIMEOUT;
`endif

endmodule

// File: tb/tb_wshb_arbiter_n.sv
// tb/tb_wshb_arbiter_n.sv - self-checking bench for wshb_arbiter_n with a round-robin reference model.
module tb_wshb_arbiter_n;

  localparam int N  = 4;
  localparam int DB = 2;
  localparam int AW = 32;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat_ms = '0;
  logic [N*DB-1:0] m_sel = '0;
  logic [DW-1:0]   m_dat_sm;
  logic [N-1:0]    m_ack, m_rty, grant_o;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_ms;
  logic [DW-1:0]   s_dat_sm = '0;
  logic [DB-1:0]   s_sel;
  logic            s_ack = 1'b0, s_rty = 1'b0;
`ifdef WSHB_ARB_TIMEOUT_EN
  logic            timeout_o;
`endif

  int checks = 0;
  int failures = 0;
  int model_last = N - 1;

  wshb_arbiter_n #(
    .NB_MASTERS(N), .DATA_BYTES(DB), .ADDR_W(AW), .ADDR_SHIFT(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_dat_sm(m_dat_sm),
    .m_ack(m_ack), .m_rty(m_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_dat_sm(s_dat_sm),
    .s_ack(s_ack), .s_rty(s_rty), .grant_o(grant_o)
`ifdef WSHB_ARB_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_rty = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    model_last = N - 1;
  endtask

  task automatic idle_all();
    m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_rty = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_cyc = '0; m_stb = '0;
    tick();
    #1;
    checks++; if (grant_o !== '0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
    checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin failures++; $display("FAIL reset_s_ctl got=%b exp=000", {s_cyc, s_stb, s_we}); end
    checks++; if (s_adr !== '0) begin failures++; $display("FAIL reset_s_adr got=%h exp=0", s_adr); end
    checks++; if ({m_ack, m_rty} !== '0) begin failures++; $display("FAIL reset_m_ack_rty got=%b exp=0", {m_ack, m_rty}); end
`ifdef WSHB_ARB_TIMEOUT_EN
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
`endif
    apply_reset();
  endtask

  task automatic test_single_read();
    logic [DW-1:0] d;
    int acks;
    acks = 0;
    m_adr[0 +: AW] = 32'h100; m_sel[0 +: DB] = 2'b11; m_we = '0;
    m_cyc = 4'b0001; m_stb = 4'b0001;
    #1;
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL single_latency got=%b exp=0", s_cyc); end
    tick(); #1;
    checks++; if (s_cyc !== 1'b1) begin failures++; $display("FAIL single_s_cyc got=%b exp=1", s_cyc); end
    checks++; if (s_adr !== 32'h200) begin failures++; $display("FAIL single_s_adr got=%h exp=200", s_adr); end
    checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", grant_o); end
    acks += int'(m_ack[0]);
    tick(); #1; acks += int'(m_ack[0]);
    tick(); s_ack = 1'b1; d = DW'($urandom); s_dat_sm = d; #1;
    acks += int'(m_ack[0]);
    checks++; if (m_dat_sm !== d) begin failures++; $display("FAIL single_rdata got=%h exp=%h", m_dat_sm, d); end
    tick(); s_ack = 1'b0; m_cyc = '0; m_stb = '0; #1;
    acks += int'(m_ack[0]);
    checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL single_release got=%b exp=0", s_cyc); end
    checks++; if (acks !== 1) begin failures++; $display("FAIL single_ack_count got=%0d exp=1", acks); end
    tick(); #1;
    checks++; if (grant_o !== '0) begin failures++; $display("FAIL single_idle got=%b exp=0000", grant_o); end
    model_last = 0;
    idle_all();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    m_cyc = 4'b0011; m_stb = 4'b0011;
    tick(); #1;
    checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL simul_first got=%b exp=0001", grant_o); end
    tick(); s_ack = 1'b1; #1;
    checks++; if (m_ack !== 4'b0001) begin failures++; $display("FAIL simul_ack0 got=%b exp=0001", m_ack); end
    tick(); s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; #1;
    tick(); #1;
    checks++; if (grant_o !== 4'b0000) begin failures++; $display("FAIL simul_gap got=%b exp=0000", grant_o); end
    tick(); #1;
    checks++; if (grant_o !== 4'b0010) begin failures++; $display("FAIL simul_second got=%b exp=0010", grant_o); end
    tick(); m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b1; #1;
    checks++; if (m_ack !== 4'b0000) begin failures++; $display("FAIL late_ack_ignored got=%b exp=0000", m_ack); end
    model_last = 1;
    idle_all();
  endtask

  task automatic test_burst();
    int acks0, leak1;
    logic [N-1:0] exp_g;
    acks0 = 0; leak1 = 0;
    exp_g = '0; exp_g[model_pick(4'b0011, model_last)] = 1'b1;
    m_cyc = 4'b0011; m_stb = 4'b0011;
    tick(); #1;
    checks++; if (grant_o !== exp_g) begin failures++; $display("FAIL burst_grant got=%b exp=%b", grant_o, exp_g); end
    for (int b = 0; b < 8; b++) begin
      tick(); s_ack = 1'b1; #1;
      acks0 += int'(m_ack[0]);
      leak1 += int'(m_ack[1]);
    end
    tick(); s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; #1;
    leak1 += int'(m_ack[1]);
    checks++; if (acks0 !== 8) begin failures++; $display("FAIL burst_acks got=%0d exp=8", acks0); end
    checks++; if (leak1 !== 0) begin failures++; $display("FAIL burst_leak got=%0d exp=0", leak1); end
    tick(); tick(); s_ack = 1'b1; #1;
    checks++; if (m_ack !== 4'b0010) begin failures++; $display("FAIL burst_next_ack got=%b exp=0010", m_ack); end
    model_last = 1;
    idle_all();
  endtask

  task automatic test_alternate();
    logic [N-1:0] req, exp_g, seen;
    int g;
    req = 4'b1010; seen = '0;
    m_cyc = req; m_stb = req;
    for (int n = 0; n < 6; n++) begin
      g = model_pick(req, model_last);
      exp_g = '0; exp_g[g] = 1'b1;
      for (int w = 0; w < 4 && grant_o == '0; w++) begin tick(); #1; end
      seen |= grant_o;
      checks++; if (grant_o !== exp_g) begin failures++; $display("FAIL alt_grant%0d got=%b exp=%b", n, grant_o, exp_g); end
      tick(); s_ack = 1'b1; #1;
      tick(); s_ack = 1'b0; m_cyc[g] = 1'b0; m_stb[g] = 1'b0; #1;
      tick(); m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
      model_last = g;
    end
    checks++; if (seen !== 4'b1010) begin failures++; $display("FAIL alt_coverage got=%b exp=1010", seen); end
    idle_all();
  endtask

  task automatic test_random();
    logic [N-1:0]  pending, exp_g;
    logic [AW-1:0] adr [N];
    logic [DW-1:0] dat [N];
    logic [DB-1:0] sel [N];
    logic          we  [N];
    logic [DW-1:0] rd;
    int g, beats;
    for (int r = 0; r < 8; r++) begin
      pending = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        adr[i] = $urandom; dat[i] = DW'($urandom); sel[i] = DB'($urandom); we[i] = 1'($urandom);
        m_adr[i*AW +: AW] = adr[i]; m_dat_ms[i*DW +: DW] = dat[i];
        m_sel[i*DB +: DB] = sel[i]; m_we[i] = we[i];
      end
      m_cyc = pending; m_stb = pending;
      while (pending != '0) begin
        g = model_pick(pending, model_last);
        exp_g = '0; exp_g[g] = 1'b1;
        for (int w = 0; w < 4 && grant_o == '0; w++) begin tick(); #1; end
        checks++; if (grant_o !== exp_g) begin failures++; $display("FAIL rnd_grant got=%b exp=%b", grant_o, exp_g); end
        checks++; if (s_adr !== AW'(64'(adr[g]) * 2)) begin failures++; $display("FAIL rnd_adr got=%h exp=%h", s_adr, AW'(64'(adr[g]) * 2)); end
        checks++; if ({s_we, s_sel, s_dat_ms} !== {we[g], sel[g], dat[g]}) begin failures++; $display("FAIL rnd_payload got=%h exp=%h", {s_we, s_sel, s_dat_ms}, {we[g], sel[g], dat[g]}); end
        beats = $urandom_range(1, 3);
        for (int b = 0; b < beats; b++) begin
          tick(); s_ack = 1'b1; rd = DW'($urandom); s_dat_sm = rd; #1;
          checks++; if ({m_ack, m_dat_sm} !== {exp_g, rd}) begin failures++; $display("FAIL rnd_ack got=%h exp=%h", {m_ack, m_dat_sm}, {exp_g, rd}); end
        end
        tick(); s_ack = 1'b0; s_rty = 1'b1; #1;
        checks++; if (m_rty !== exp_g) begin failures++; $display("FAIL rnd_rty got=%b exp=%b", m_rty, exp_g); end
        tick(); s_rty = 1'b0; m_cyc[g] = 1'b0; m_stb[g] = 1'b0; pending[g] = 1'b0; #1;
        checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL rnd_release got=%b exp=0", s_cyc); end
        tick(); #1;
        checks++; if (grant_o !== '0) begin failures++; $display("FAIL rnd_gap got=%b exp=0000", grant_o); end
        model_last = g;
      end
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100;
    tick(); #1;
    checks++; if (s_cyc !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%b exp=1", s_cyc); end
    reset_n = 1'b0; #1;
    checks++; if ({s_cyc, s_stb, s_we, grant_o} !== '0) begin failures++; $display("FAIL midrst_async got=%b exp=0", {s_cyc, s_stb, s_we, grant_o}); end
    m_cyc = 4'b0011; m_stb = 4'b0011; m_we = '0;
    tick();
    reset_n = 1'b1;
    model_last = N - 1;
    tick(); #1;
    checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL midrst_priority got=%b exp=0001", grant_o); end
    model_last = 0;
    idle_all();
  endtask

  task automatic test_stall();
    logic [N-1:0] exp_g, other_g;
    int g, stall_bad;
    stall_bad = 0;
    g = model_pick(4'b0011, model_last);
    exp_g = '0; exp_g[g] = 1'b1;
    other_g = 4'b0011 & ~exp_g;
    m_cyc = 4'b0011; m_stb = 4'b0011;
    for (int w = 0; w < 4 && grant_o == '0; w++) begin tick(); #1; end
    checks++; if (grant_o !== exp_g) begin failures++; $display("FAIL stall_grant got=%b exp=%b", grant_o, exp_g); end
    for (int k = 1; k < 16; k++) begin
      if (m_rty !== '0 || s_cyc !== 1'b1) stall_bad++;
      tick(); #1;
    end
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL stall_early got=%0d exp=0", stall_bad); end
`ifdef WSHB_ARB_TIMEOUT_EN
    checks++; if ({m_rty, s_cyc} !== {exp_g, 1'b0}) begin failures++; $display("FAIL timeout_pulse got=%b exp=%b", {m_rty, s_cyc}, {exp_g, 1'b0}); end
    tick(); m_cyc[g] = 1'b0; m_stb[g] = 1'b0; #1;
    checks++; if ({timeout_o, grant_o} !== {1'b1, 4'b0000}) begin failures++; $display("FAIL timeout_sticky got=%b exp=%b", {timeout_o, grant_o}, {1'b1, 4'b0000}); end
    tick(); #1;
    checks++; if (grant_o !== other_g) begin failures++; $display("FAIL timeout_next got=%b exp=%b", grant_o, other_g); end
`else
    for (int k = 0; k < 8; k++) begin tick(); #1; end
    checks++; if ({grant_o, m_rty, s_cyc} !== {exp_g, 4'b0000, 1'b1}) begin failures++; $display("FAIL stall_hold got=%b exp=%b", {grant_o, m_rty, s_cyc}, {exp_g, 4'b0000, 1'b1}); end
    checks++; if (other_g == '0 || (grant_o & other_g) !== '0) begin failures++; $display("FAIL stall_no_preempt got=%b exp=%b", grant_o, exp_g); end
`endif
    idle_all();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_burst();
    test_alternate();
    test_random();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
